uart_debug_rx: RTL and testbench



---
 rtl/uart_debug_rx.sv | 206 ++++++++++++++++++++
 tb/tb_uart_debug_rx.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_debug_rx.sv
// 8N1 UART receiver into a first-word-fall-through byte FIFO. Bytes are pushed at the stop-bit sample and are visible on the next cycle.
// When the FIFO is full, a new byte is dropped and io_overflow pulses. Defining UART_DEBUG_RX_PARITY_EN switches the frame to 8E1 and adds io_parityError.
module uart_debug_rx #(
    parameter int CLK_FREQ   = 75000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            io_mainClk,
    input  logic                            io_asyncReset_n,
    input  logic                            io_rxd,
    output logic                            io_rsp_valid,
    input  logic                            io_rsp_ready,
    output logic [7:0]                      io_rsp_payload,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] io_occupancy,
    output logic                            io_frameError,
    output logic                            io_overflow,
`ifdef UART_DEBUG_RX_PARITY_EN
    output logic                            io_parityError,
`endif
    output logic                            io_break
);
    localparam int CLKS_PER_BIT = (CLK_FREQ + BAUD/2) / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int BW           = $clog2(CLKS_PER_BIT);
    localparam int AW           = $clog2(FIFO_DEPTH);
    localparam int CW           = $clog2(FIFO_DEPTH+1);
    localparam logic [BW-1:0] RELOAD_BIT  = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] RELOAD_HALF = BW'(HALF_BIT - 1);
    localparam logic [CW-1:0] DEPTH_C     = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BREAK_WAIT
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_rxd_meta;
    logic          r_rxd_s;
    logic [1:0]    r_fill;
    logic          r_armed;
    logic [BW-1:0] r_baud_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          w_tick;
    logic          w_load_half;
    logic          w_load_bit;
    logic          w_shift;
    logic          w_stop_smp;
    logic          w_push_req;
`ifdef UART_DEBUG_RX_PARITY_EN
    logic          r_par_bit;
    logic          w_par_smp;
    logic          w_par_bad;
`endif

    // The synchronizer resets high, so a line held low through reset is only
    // trusted once two genuine samples have flowed through and one reads high.
    always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
        if (!io_asyncReset_n) begin
            r_rxd_meta <= 1'b1;
            r_rxd_s    <= 1'b1;
            r_fill     <= 2'b00;
            r_armed    <= 1'b0;
        end else begin
            r_rxd_meta <= io_rxd;
            r_rxd_s    <= r_rxd_meta;
            r_fill     <= {r_fill[0], 1'b1};
            if (r_fill[1] && r_rxd_s) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign w_tick = (r_baud_cnt == '0);

    always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
        if (!io_asyncReset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:       if (r_armed && !r_rxd_s) w_next = ST_START;
            ST_START:      if (w_tick) w_next = r_rxd_s ? ST_IDLE : ST_DATA;
`ifdef UART_DEBUG_RX_PARITY_EN
            ST_DATA:       if (w_tick && r_bit_idx == 3'd7) w_next = ST_PARITY;
            ST_PARITY:     if (w_tick) w_next = ST_STOP;
`else
            ST_DATA:       if (w_tick && r_bit_idx == 3'd7) w_next = ST_STOP;
`endif
            ST_STOP:       if (w_tick) w_next = r_rxd_s ? ST_IDLE : ST_BREAK_WAIT;
            ST_BREAK_WAIT: if (r_rxd_s) w_next = ST_IDLE;
            default:       w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_load_half = 1'b0;
        w_load_bit  = 1'b0;
        w_shift     = 1'b0;
        w_stop_smp  = 1'b0;
`ifdef UART_DEBUG_RX_PARITY_EN
        w_par_smp   = 1'b0;
`endif
        case (r_state)
            ST_IDLE:  w_load_half = r_armed && !r_rxd_s;
            ST_START: w_load_bit  = w_tick && !r_rxd_s;
            ST_DATA: begin
                w_load_bit = w_tick;
                w_shift    = w_tick;
            end
`ifdef UART_DEBUG_RX_PARITY_EN
            ST_PARITY: begin
                w_load_bit = w_tick;
                w_par_smp  = w_tick;
            end
`endif
            ST_STOP:  w_stop_smp = w_tick;
            default:  ;
        endcase
        io_frameError = w_stop_smp && !r_rxd_s;
        io_break      = w_stop_smp && !r_rxd_s && (r_shift == 8'h00);
`ifdef UART_DEBUG_RX_PARITY_EN
        w_par_bad      = (r_par_bit != ^r_shift);
        io_parityError = w_stop_smp && r_rxd_s && w_par_bad;
        w_push_req     = w_stop_smp && r_rxd_s && !w_par_bad;
`else
        w_push_req     = w_stop_smp && r_rxd_s;
`endif
    end

    always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
        if (!io_asyncReset_n) begin
            r_baud_cnt <= '0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'h00;
        end else begin
            if (w_load_half) begin
                r_baud_cnt <= RELOAD_HALF;
            end else if (w_load_bit) begin
                r_baud_cnt <= RELOAD_BIT;
            end else if (!w_tick) begin
                r_baud_cnt <= r_baud_cnt - 1'b1;
            end
            if (w_load_half) begin
                r_bit_idx <= 3'd0;
            end else if (w_shift) begin
                r_bit_idx          <= r_bit_idx + 1'b1;
                r_shift[r_bit_idx] <= r_rxd_s;
            end
        end
    end

`ifdef UART_DEBUG_RX_PARITY_EN
    always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
        if (!io_asyncReset_n) begin
            r_par_bit <= 1'b0;
        end else if (w_par_smp) begin
            r_par_bit <= r_rxd_s;
        end
    end
`endif

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_full;
    logic          w_pop;
    logic          w_push;

    assign io_rsp_valid   = (r_count != '0);
    assign w_full         = (r_count == DEPTH_C);
    assign w_pop          = io_rsp_valid && io_rsp_ready;
    // A simultaneous pop frees the slot, so a full FIFO still accepts the byte.
    assign w_push         = w_push_req && (!w_full || w_pop);
    assign io_overflow    = w_push_req && w_full && !w_pop;
    assign io_rsp_payload = io_rsp_valid ? r_mem[r_rd_ptr] : 8'h00;
    assign io_occupancy   = r_count;

    always_ff @(posedge io_mainClk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
        if (!io_asyncReset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_debug_rx.sv
// Self-checking bench for uart_debug_rx: directed scenarios plus randomized frames against a queue-based reference model.
`timescale 1ns/1ps
module tb_uart_debug_rx;
    localparam int CLK_FREQ = 1600000;
    localparam int BAUD     = 100000;
    localparam int DEPTH    = 4;
    localparam int CPB      = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd = 1'b1;
    logic       rdy_dir = 1'b0;
    logic       rnd_en = 1'b0;
    logic       rnd_rdy = 1'b0;
    logic       rsp_ready;
    logic       rsp_valid;
    logic [7:0] rsp_payload;
    logic [2:0] occ;
    logic       fe;
    logic       ovf;
    logic       brk;
    logic       perr;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt_fe = 0, cnt_ovf = 0, cnt_brk = 0, cnt_perr = 0;
    int exp_fe = 0, exp_ovf = 0, exp_brk = 0, exp_perr = 0;
    logic [7:0] q_exp[$];

    assign rsp_ready = rnd_en ? rnd_rdy : rdy_dir;

    uart_debug_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
        .io_mainClk      (clk),
        .io_asyncReset_n (rst_n),
        .io_rxd          (rxd),
        .io_rsp_valid    (rsp_valid),
        .io_rsp_ready    (rsp_ready),
        .io_rsp_payload  (rsp_payload),
        .io_occupancy    (occ),
        .io_frameError   (fe),
        .io_overflow     (ovf),
`ifdef UART_DEBUG_RX_PARITY_EN
        .io_parityError  (perr),
`endif
        .io_break        (brk)
    );
`ifndef UART_DEBUG_RX_PARITY_EN
    assign perr = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_pulses(input string tag);
        chk({tag, "_frameError"}, cnt_fe, exp_fe);
        chk({tag, "_break"}, cnt_brk, exp_brk);
        chk({tag, "_overflow"}, cnt_ovf, exp_ovf);
        chk({tag, "_parityError"}, cnt_perr, exp_perr);
    endtask

    // Model: decide the fate of the frame from the line rules, then drive it.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
        if (!stop_bit) begin
            exp_fe++;
            if (d == 8'h00) exp_brk++;
        end else if (par_flip) begin
            exp_perr++;
        end else if (!rnd_en && !rdy_dir && q_exp.size() >= DEPTH) begin
            exp_ovf++;
        end else begin
            q_exp.push_back(d);
        end
        rxd = 1'b0;
        cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            cyc(CPB);
        end
`ifdef UART_DEBUG_RX_PARITY_EN
        rxd = (^d) ^ par_flip;
        cyc(CPB);
`endif
        rxd = stop_bit;
        cyc(CPB);
        rxd = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (fe)   cnt_fe++;
            if (ovf)  cnt_ovf++;
            if (brk)  cnt_brk++;
            if (perr) cnt_perr++;
            if (rsp_valid && rsp_ready) begin
                chk("pop_model_has_byte", 32'(q_exp.size() != 0), 32'd1);
                if (q_exp.size() != 0) chk("pop_payload", rsp_payload, q_exp.pop_front());
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rnd_rdy = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        logic [7:0] d;
        logic       sb;
        logic       pf;
        cyc(3);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_occupancy", occ, 0);
        chk("rst_payload", rsp_payload, 0);
        chk("rst_pulses", {fe, ovf, brk, perr}, 0);
        rst_n = 1'b1;
        cyc(5);

        // two back-to-back bytes held in the FIFO
        send_frame(8'h55, 1'b1, 1'b0);
        send_frame(8'hA3, 1'b1, 1'b0);
        cyc(4);
        chk("two_occupancy", occ, 2);
        chk("two_head", rsp_payload, 8'h55);
        rdy_dir = 1'b1;
        cyc(4);
        chk("two_drained", occ, 0);
        chk_pulses("two");

        // short low glitch from idle
        rdy_dir = 1'b0;
        rxd = 1'b0;
        cyc(4);
        rxd = 1'b1;
        cyc(40);
        chk("glitch_occupancy", occ, 0);
        chk_pulses("glitch");

        // framing error, then a good frame
        send_frame(8'h3C, 1'b0, 1'b0);
        cyc(CPB);
        chk_pulses("frame_err");
        chk("frame_err_occupancy", occ, 0);
        send_frame(8'h7E, 1'b1, 1'b0);
        cyc(4);
        chk("after_fe_occupancy", occ, 1);
        chk("after_fe_head", rsp_payload, 8'h7E);
        rdy_dir = 1'b1;
        cyc(4);

        // break: line low for 30 bit times
        exp_fe++;
        exp_brk++;
        rxd = 1'b0;
        cyc(30 * CPB);
        chk_pulses("break");
        rxd = 1'b1;
        cyc(CPB);
        send_frame(8'h11, 1'b1, 1'b0);
        cyc(4);
        chk("break_model_empty", q_exp.size(), 0);

        // overflow on the fifth byte with the consumer stalled
        rdy_dir = 1'b0;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0);
        cyc(4);
        chk("ovf_occupancy", occ, DEPTH);
        chk("ovf_head", rsp_payload, 8'h01);
        chk_pulses("ovf");
        rdy_dir = 1'b1;
        cyc(8);
        chk("ovf_drained", occ, 0);
        chk("ovf_model_empty", q_exp.size(), 0);

        // reset in the middle of DATA while the FIFO holds a byte
        rdy_dir = 1'b0;
        send_frame(8'h5A, 1'b1, 1'b0);
        cyc(4);
        chk("pre_reset_occupancy", occ, 1);
        rxd = 1'b0;
        cyc(CPB + CPB + CPB / 2);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_valid", rsp_valid, 0);
        chk("mid_reset_occupancy", occ, 0);
        chk("mid_reset_payload", rsp_payload, 0);
        q_exp.delete();
        cyc(3);
        rst_n = 1'b1;
        cyc(40);
        chk("post_reset_low_occupancy", occ, 0);
        rxd = 1'b1;
        cyc(3 * CPB);
        send_frame(8'hC6, 1'b1, 1'b0);
        cyc(4);
        chk("post_reset_occupancy", occ, 1);
        chk("post_reset_head", rsp_payload, 8'hC6);
        rdy_dir = 1'b1;
        cyc(4);
        chk("post_reset_drained", occ, 0);
        chk_pulses("post_reset");

`ifdef UART_DEBUG_RX_PARITY_EN
        rdy_dir = 1'b0;
        send_frame(8'hC6, 1'b1, 1'b1);
        cyc(4);
        chk("parity_occupancy", occ, 0);
        chk_pulses("parity");
        rdy_dir = 1'b1;
`endif

        // randomized frames with a randomly stalling consumer
        rnd_en = 1'b1;
        for (int n = 0; n < 24; n++) begin
            d  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            sb = ($urandom_range(0, 5) != 0);
            pf = 1'b0;
`ifdef UART_DEBUG_RX_PARITY_EN
            pf = ($urandom_range(0, 5) == 0);
`endif
            send_frame(d, sb, pf);
            cyc($urandom_range(1, 40) + (sb ? 0 : CPB));
        end
        rnd_en = 1'b0;
        rdy_dir = 1'b1;
        cyc(40);
        chk("final_model_empty", q_exp.size(), 0);
        chk("final_occupancy", occ, 0);
        chk_pulses("final");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
